// File: rtl/result_bcd_pkg.sv
// Shared definitions for the binary-to-BCD display converter: FSM encoding and
// the decimal digit-count helper used to size-check the BCD output.
package result_bcd_pkg;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_CONVERT = 1'b1
  } state_t;

  // Number of decimal digits needed to show the largest w-bit unsigned value.
  function automatic int digits_needed(input int w);
    longint max_val;
    int     n;
    max_val = (longint'(1) << w) - 1;
    n       = 1;
    max_val = max_val / 10;
    while (max_val > 0) begin
      n       = n + 1;
      max_val = max_val / 10;
    end
    return n;
  endfunction

endpackage

// File: rtl/result_bcd_converter_adjust.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_adjust_digit (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter: turns the evaluator's unsigned result into
// packed BCD digits for the hex_decoder displays, one shift per clock.
module result_bcd_converter
  import result_bcd_pkg::*;
#(
  parameter int W      = 8,
  parameter int DIGITS = 3,
  parameter int AUTO   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W-1:0]          bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  if (DIGITS < digits_needed(W)) begin : g_digits_check
    $error("result_bcd_converter: DIGITS too small to represent 2^W-1");
  end

  state_t             state, state_nxt;
  logic [W-1:0]       shift_reg;
  logic [W-1:0]       last_val;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   scratch_shf;
  logic [CNT_W-1:0]   count;
  logic               trigger;
  logic               last_step;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
    bcd_adjust_digit u_adjust (
      .digit_in  (scratch[4*g +: 4]),
      .digit_out (scratch_adj[4*g +: 4])
    );
  end

  // The bit shifted out of the top nibble is always 0 given the DIGITS check.
  assign scratch_shf = {scratch_adj[BCD_W-2:0], shift_reg[W-1]};
  assign last_step   = (count == CNT_W'(W - 1));

  always_comb begin
    state_nxt = state;
    trigger   = 1'b0;
    case (state)
      S_IDLE: begin
        trigger = start | ((AUTO != 0) && (bin_in != last_val));
        if (trigger) state_nxt = S_CONVERT;
      end
      S_CONVERT: begin
        if (last_step) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_CONVERT);
      done  <= (state == S_CONVERT) && last_step;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      last_val  <= '0;
      scratch   <= '0;
      count     <= '0;
      bcd_out   <= '0;
    end else if ((state == S_IDLE) && trigger) begin
      shift_reg <= bin_in;
      last_val  <= bin_in;
      scratch   <= '0;
      count     <= '0;
    end else if (state == S_CONVERT) begin
      scratch   <= scratch_shf;
      shift_reg <= shift_reg << 1;
      count     <= last_step ? '0 : (count + CNT_W'(1));
      if (last_step) bcd_out <= scratch_shf;
    end
  end

endmodule
